// File: rtl/writeback_arbiter_if.sv
// Writeback bundle between the three producers, the issue stage, the
// register file write port and the arbiter. Three requester slots, a
// registered write port, a reserve port and the pending-write vector.
interface writeback_arbiter_if;
  logic [2:0]  ReqValid;
  logic [2:0]  ReqReady;
  logic [4:0]  ReqTarget0;
  logic [4:0]  ReqTarget1;
  logic [4:0]  ReqTarget2;
  logic [31:0] ReqData0;
  logic [31:0] ReqData1;
  logic [31:0] ReqData2;
  logic [31:0] WriteData;
  logic [4:0]  WriteTarget;
  logic        WriteEnable;
  logic        ReserveEnable;
  logic [4:0]  ReserveTarget;
  logic        Flush;
  logic [31:0] Pending;

  // Producers, issue stage and register file: drive requests, observe results.
  modport master (
    output ReqValid, ReqTarget0, ReqTarget1, ReqTarget2,
    output ReqData0, ReqData1, ReqData2,
    output ReserveEnable, ReserveTarget, Flush,
    input  ReqReady, WriteData, WriteTarget, WriteEnable, Pending
  );

  // The arbiter itself.
  modport slave (
    input  ReqValid, ReqTarget0, ReqTarget1, ReqTarget2,
    input  ReqData0, ReqData1, ReqData2,
    input  ReserveEnable, ReserveTarget, Flush,
    output ReqReady, WriteData, WriteTarget, WriteEnable, Pending
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register file write port among the ALU (0),
// load unit (1) and multiplier (2). The winner is registered onto the write
// port one cycle after grant. A 32-bit pending-write scoreboard is set by
// dispatch and cleared by the retiring write so decode can stall on hazards.
module writeback_arbiter #(
  parameter int NREQ = 3  // round-robin rotation below is sized for exactly 3
) (
  input  logic                Clock,
  input  logic                Reset_n,
  writeback_arbiter_if.slave  wb
);

  logic [4:0]  req_tgt  [NREQ];
  logic [31:0] req_data [NREQ];

  logic [1:0]  last_grant;
  logic        grant;
  logic [1:0]  winner;
  logic [1:0]  cand;
  logic [4:0]  win_tgt;
  logic [31:0] win_data;

  logic        wr_en_q;
  logic [4:0]  wr_tgt_q;
  logic [31:0] wr_data_q;

  // Register 0 is hard-wired, so only bits 31..1 carry state.
  logic [31:1] pending_q;
  logic [31:1] pending_next;

  assign req_tgt[0]  = wb.ReqTarget0;
  assign req_tgt[1]  = wb.ReqTarget1;
  assign req_tgt[2]  = wb.ReqTarget2;
  assign req_data[0] = wb.ReqData0;
  assign req_data[1] = wb.ReqData1;
  assign req_data[2] = wb.ReqData2;

  // (base + offset) mod 3 for base in 0..2 and offset in 1..3.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [2:0] offset);
    logic [2:0] sum;
    sum = {1'b0, base} + offset;
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // Pick the first valid requester after last_grant in rotation order.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant  = 1'b0;
    winner = 2'd0;
    cand   = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = rr_index(last_grant, 3'(k));
      if (!grant && wb.ReqValid[cand]) begin
        grant  = 1'b1;
        winner = cand;
      end
    end
    // Nothing may be accepted while held in reset, independent of the clock.
    if (!Reset_n) grant = 1'b0;
  end

  assign win_tgt     = req_tgt[winner];
  assign win_data    = req_data[winner];
  assign wb.ReqReady = grant ? (3'b001 << winner) : 3'b000;

  // Rotation pointer: remember the last winner, hold when idle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!Reset_n) begin
      last_grant <= 2'd2;  // requester 0 is first in line out of reset
    end else if (grant) begin
      last_grant <= winner;
    end
  end

  // Write-port register: a write to r0 is consumed but never enabled.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_en_q   <= 1'b0;
      wr_tgt_q  <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      wr_en_q <= grant && (win_tgt != 5'd0);
      if (grant) begin
        wr_tgt_q  <= win_tgt;
        wr_data_q <= win_data;
      end
    end
  end

  assign wb.WriteEnable = wr_en_q;
  assign wb.WriteTarget = wr_tgt_q;
  assign wb.WriteData   = wr_data_q;

  // Scoreboard next state: reserve beats flush beats retire.
  always_comb begin
    pending_next = pending_q;
    for (int r = 1; r < 32; r++) begin
      if (wb.ReserveEnable && wb.ReserveTarget == 5'(r)) begin
        pending_next[r] = 1'b1;
      end else if (wb.Flush) begin
        pending_next[r] = 1'b0;
      end else if (wr_en_q && wr_tgt_q == 5'(r)) begin
        pending_next[r] = 1'b0;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  assign wb.Pending = {pending_q, 1'b0};

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic.
// A behavioural model predicts grants and scoreboard contents; expected
// register-file writes go into a queue consumed by an independent monitor.
module tb_writeback_arbiter;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  writeback_arbiter_if wb();

  writeback_arbiter #(.NREQ(3)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .wb      (wb)
  );

  initial forever #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic [4:0]  tgt;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state.
  int          lg_m;
  logic [31:0] pend_m;
  logic        cur_we_m;
  logic [4:0]  cur_tgt_m;
  logic        hv [3];
  logic [4:0]  ht [3];
  logic [31:0] hd [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    lg_m      = 2;
    pend_m    = 32'd0;
    cur_we_m  = 1'b0;
    cur_tgt_m = 5'd0;
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      ht[i] = 5'd0;
      hd[i] = 32'd0;
    end
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input logic [4:0] t, input logic [31:0] d);
    hv[i] = 1'b1;
    ht[i] = t;
    hd[i] = d;
  endtask

  // One cycle: drive at negedge, predict, then check the scoreboard a cycle later.
  task automatic step(input logic res_en, input logic [4:0] res_tgt, input logic flush,
                      output int granted);
    int win;
    wb.ReqValid      = {hv[2], hv[1], hv[0]};
    wb.ReqTarget0    = ht[0];
    wb.ReqTarget1    = ht[1];
    wb.ReqTarget2    = ht[2];
    wb.ReqData0      = hd[0];
    wb.ReqData1      = hd[1];
    wb.ReqData2      = hd[2];
    wb.ReserveEnable = res_en;
    wb.ReserveTarget = res_tgt;
    wb.Flush         = flush;
    #1;
    win = -1;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (lg_m + k) % 3;
      if (win < 0 && hv[c]) win = c;
    end
    check("ReqReady", 32'(wb.ReqReady), (win < 0) ? 32'd0 : (32'd1 << win));
    for (int r = 1; r < 32; r++) begin
      if (res_en && res_tgt == 5'(r)) pend_m[r] = 1'b1;
      else if (flush)                 pend_m[r] = 1'b0;
      else if (cur_we_m && cur_tgt_m == 5'(r)) pend_m[r] = 1'b0;
    end
    if (win >= 0) begin
      lg_m      = win;
      cur_we_m  = (ht[win] != 5'd0);
      cur_tgt_m = ht[win];
      if (ht[win] != 5'd0) exp_q.push_back('{cyc + 1, ht[win], hd[win]});
      hv[win] = 1'b0;
    end else begin
      cur_we_m = 1'b0;
    end
    granted = win;
    @(negedge Clock);
    check("Pending", wb.Pending, pend_m);
  endtask

  // Monitor: every cycle the write port must match the queue head or be idle.
  initial begin
    wr_t e;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
        e = exp_q.pop_front();
        check("WriteEnable", 32'(wb.WriteEnable), 32'd1);
        check("WriteTarget", 32'(wb.WriteTarget), 32'(e.tgt));
        check("WriteData",   wb.WriteData, e.data);
      end else begin
        check("WriteEnable_idle", 32'(wb.WriteEnable), 32'd0);
      end
    end
  end

  initial begin
    int g;
    model_reset();
    wb.ReqValid      = 3'b111;
    wb.ReqTarget0    = 5'd5;
    wb.ReqTarget1    = 5'd6;
    wb.ReqTarget2    = 5'd7;
    wb.ReqData0      = 32'hA;
    wb.ReqData1      = 32'hB;
    wb.ReqData2      = 32'hC;
    wb.ReserveEnable = 1'b0;
    wb.ReserveTarget = 5'd0;
    wb.Flush         = 1'b0;

    // Held in reset with all requesters valid.
    repeat (2) @(negedge Clock);
    check("reset_ReqReady",    32'(wb.ReqReady), 32'd0);
    check("reset_WriteEnable", 32'(wb.WriteEnable), 32'd0);
    check("reset_WriteTarget", 32'(wb.WriteTarget), 32'd0);
    check("reset_WriteData",   wb.WriteData, 32'd0);
    check("reset_Pending",     wb.Pending, 32'd0);
    Reset_n = 1'b1;

    // Round-robin with all three held valid.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 5'd5, 32'hA);
      set_req(1, 5'd6, 32'hB);
      set_req(2, 5'd7, 32'hC);
      step(1'b0, 5'd0, 1'b0, g);
      check("rr_order", 32'(g), 32'(i % 3));
    end
    for (int i = 0; i < 3; i++) hv[i] = 1'b0;

    // Single requester served every cycle.
    for (int i = 0; i < 4; i++) begin
      set_req(2, 5'd9, 32'hDEADBEEF);
      step(1'b0, 5'd0, 1'b0, g);
      check("single_grant", 32'(g), 32'd2);
    end
    step(1'b0, 5'd0, 1'b0, g);

    // Register 0: consumed without a write; reserving it is ignored.
    set_req(1, 5'd0, 32'h1234);
    step(1'b0, 5'd0, 1'b0, g);
    check("r0_grant", 32'(g), 32'd1);
    step(1'b1, 5'd0, 1'b0, g);
    check("r0_reserve", wb.Pending, 32'd0);

    // Scoreboard: reserve, then retire clears.
    step(1'b1, 5'd12, 1'b0, g);
    check("sb_set", 32'(wb.Pending[12]), 32'd1);
    set_req(0, 5'd12, 32'h0000_1212);
    step(1'b0, 5'd0, 1'b0, g);
    step(1'b0, 5'd0, 1'b0, g);
    check("sb_retire", 32'(wb.Pending[12]), 32'd0);
    // Reserve on the retire edge wins.
    step(1'b1, 5'd12, 1'b0, g);
    set_req(0, 5'd12, 32'h0000_3434);
    step(1'b0, 5'd0, 1'b0, g);
    step(1'b1, 5'd12, 1'b0, g);
    check("sb_reserve_wins", 32'(wb.Pending[12]), 32'd1);

    // Flush.
    step(1'b0, 5'd0, 1'b1, g);
    for (int r = 4; r < 8; r++) begin
      step(1'b1, 5'(r), 1'b0, g);
      step(1'b1, 5'(r + 8), 1'b0, g);
    end
    check("flush_setup", wb.Pending, 32'h0000_F0F0);
    step(1'b0, 5'd0, 1'b1, g);
    check("flush_clear", wb.Pending, 32'd0);

    // Randomized traffic with requesters holding until accepted.
    for (int i = 0; i < 400; i++) begin
      for (int q = 0; q < 3; q++) begin
        if (!hv[q] && $urandom_range(0, 9) < 6)
          set_req(q, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      end
      step($urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)),
           $urandom_range(0, 19) == 0, g);
    end
    for (int i = 0; i < 3; i++) hv[i] = 1'b0;
    step(1'b0, 5'd0, 1'b0, g);

    // Asynchronous reset while a write sits in the output register.
    step(1'b1, 5'd3, 1'b0, g);
    set_req(0, 5'd3, 32'hCAFE_F00D);
    step(1'b0, 5'd0, 1'b0, g);
    #2;
    wb.ReqValid = 3'b111;
    Reset_n = 1'b0;
    #1;
    check("async_WriteEnable", 32'(wb.WriteEnable), 32'd0);
    check("async_Pending",     wb.Pending, 32'd0);
    check("async_ReqReady",    32'(wb.ReqReady), 32'd0);
    model_reset();
    @(negedge Clock);
    Reset_n = 1'b1;
    set_req(1, 5'd20, 32'h5555_AAAA);
    set_req(2, 5'd21, 32'h6666_BBBB);
    step(1'b0, 5'd0, 1'b0, g);
    check("post_reset_grant", 32'(g), 32'd1);
    step(1'b0, 5'd0, 1'b0, g);
    step(1'b0, 5'd0, 1'b0, g);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
